// File: rtl/alu_pkg.sv
// alu_pkg: op encoding, FSM states and small op-classification helpers
// shared by the execute unit and its decoder.
package alu_pkg;

  // Class codes driven by the main decoder on ALUOp
  localparam logic [1:0] ALUOP_ADD     = 2'b00;
  localparam logic [1:0] ALUOP_SUB     = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
  localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

  typedef enum logic [4:0] {
    OP_ADD,
    OP_SUB,
    OP_SLL,
    OP_SLT,
    OP_SLTU,
    OP_XOR,
    OP_SRL,
    OP_SRA,
    OP_OR,
    OP_AND,
    OP_MUL,
    OP_MULH,
    OP_MULHSU,
    OP_MULHU,
    OP_DIV,
    OP_DIVU,
    OP_REM,
    OP_REMU,
    OP_ILLEGAL
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mdu_state_e;

  // True for every op that goes through the multiply/divide iterator
  function automatic logic is_mdu(alu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // True for the divide and remainder family
  function automatic logic is_div(alu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // True for the remainder ops, whose sign follows the dividend only
  function automatic logic is_rem(alu_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // Operand a is interpreted as two's complement
  function automatic logic op_signed_a(alu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // Operand b is interpreted as two's complement
  function automatic logic op_signed_b(alu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/alu_mdu_dec.sv
// alu_mdu_dec: combinational decode of the main-decoder class and instruction
// fields into a single ALU/MDU operation. Kept standalone for reuse.
module alu_mdu_dec
  import alu_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  output alu_op_e    op
);

  // M-extension ops exist only on R-type with funct7 bit 0 set; sub needs
  // R-type, while sra is selected by funct7 bit 5 for both R and I forms
  always_comb begin
    op = OP_ILLEGAL;
    case (ALUOp)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_FUNCT: begin
        if (opb5 && funct7b0) begin
          case (funct3)
            3'b000: op = OP_MUL;
            3'b001: op = OP_MULH;
            3'b010: op = OP_MULHSU;
            3'b011: op = OP_MULHU;
            3'b100: op = OP_DIV;
            3'b101: op = OP_DIVU;
            3'b110: op = OP_REM;
            default: op = OP_REMU;
          endcase
        end else begin
          case (funct3)
            3'b000: op = (funct7b5 && opb5) ? OP_SUB : OP_ADD;
            3'b001: op = OP_SLL;
            3'b010: op = OP_SLT;
            3'b011: op = OP_SLTU;
            3'b100: op = OP_XOR;
            3'b101: op = funct7b5 ? OP_SRA : OP_SRL;
            3'b110: op = OP_OR;
            default: op = OP_AND;
          endcase
        end
      end
      default: op = OP_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with iterative RV32M multiply/divide behind a
// valid/ready handshake. Single-cycle ops and the divide special cases
// finish straight away; multiply/divide run one radix-2 step per cycle.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic            opb5,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;

  alu_op_e           dec_op;
  mdu_state_e        state;
  alu_op_e           op_q;
  logic              neg_q;
  logic [XLEN-1:0]   opb_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   result_q;
  logic              zero_q;
  logic              illegal_q;
  logic              out_valid_q;

  logic              accept;
  logic [SW-1:0]     shamt;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   special_res;
  logic [XLEN-1:0]   direct_res;
  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              neg_next;
  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   final_res;

  alu_mdu_dec u_dec (
    .ALUOp    (ALUOp),
    .opb5     (opb5),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .funct7b0 (funct7b0),
    .op       (dec_op)
  );

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  // Single-cycle ALU on the live operands; only used on the accepting edge
  always_comb begin
    shamt   = b[SW-1:0];
    alu_res = '0;
    case (dec_op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLL:  alu_res = a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  alu_res = a ^ b;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      default: alu_res = '0;
    endcase
  end

  // Divide-by-zero and signed overflow are resolved without iterating
  always_comb begin
    div_zero    = (b == '0);
    div_ovf     = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special     = (is_div(dec_op) && div_zero) ||
                  (((dec_op == OP_DIV) || (dec_op == OP_REM)) && div_ovf);
    special_res = '0;
    case (dec_op)
      OP_DIV:  special_res = div_zero ? '1 : a;
      OP_DIVU: special_res = '1;
      OP_REM:  special_res = div_zero ? a : '0;
      OP_REMU: special_res = a;
      default: special_res = '0;
    endcase
    direct_res = is_mdu(dec_op) ? special_res : alu_res;
  end

  // The iterator works on magnitudes; remember whether to negate at the end
  always_comb begin
    a_neg    = op_signed_a(dec_op) && a[XLEN-1];
    b_neg    = op_signed_b(dec_op) && b[XLEN-1];
    mag_a    = a_neg ? (-a) : a;
    mag_b    = b_neg ? (-b) : b;
    neg_next = is_rem(dec_op) ? a_neg : (a_neg ^ b_neg);
  end

  // One shift-add multiply step or one restoring-divide step on the shared
  // accumulator, plus the sign-corrected result for the final step
  always_comb begin
    addend   = acc_q[0] ? opb_q : '0;
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend};
    div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    if (is_div(op_q)) begin
      if (!div_diff[XLEN]) begin
        acc_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {acc_q[2*XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next = {mul_sum, acc_q[XLEN-1:1]};
    end
    prod = neg_q ? (-acc_next) : acc_next;
    quo  = acc_next[XLEN-1:0];
    rem  = acc_next[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                      final_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             final_res = neg_q ? (-quo) : quo;
      OP_REM, OP_REMU:             final_res = neg_q ? (-rem) : rem;
      default:                     final_res = '0;
    endcase
  end

  // Control FSM with registered outputs; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= OP_ADD;
      neg_q       <= 1'b0;
      opb_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= dec_op;
            illegal_q <= (dec_op == OP_ILLEGAL);
            if (is_mdu(dec_op) && !special) begin
              neg_q <= neg_next;
              opb_q <= mag_b;
              acc_q <= {{XLEN{1'b0}}, mag_a};
              cnt_q <= CW'(XLEN);
              state <= CALC;
            end else begin
              result_q    <= direct_res;
              zero_q      <= (direct_res == '0);
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
        end
        CALC: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            result_q    <= final_res;
            zero_q      <= (final_res == '0);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed test of alu_mdu at XLEN=32 against an arithmetic
// reference model, with a per-cycle compare process and literal checks.
module tb_alu_mdu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic        opb5;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        funct7b0;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          due;
  } entry_t;

  entry_t exp_q[$];

  alu_mdu #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUOp     (alu_op),
    .opb5      (opb5),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .funct7b0  (funct7b0),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream never returns
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  // Reference behaviour computed with plain 64-bit arithmetic
  function automatic exp_t model(input logic [1:0] op, input logic r_type,
                                 input logic [2:0] f3, input logic f7b5,
                                 input logic f7b0, input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t   e;
    longint sx, sy, ux, uy, q;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    e.res = 32'h0;
    e.ill = 1'b0;
    e.lat = 1;
    if (op == 2'b11) begin
      e.ill = 1'b1;
    end else if (op == 2'b00) begin
      e.res = x + y;
    end else if (op == 2'b01) begin
      e.res = x - y;
    end else if (r_type && f7b0) begin
      case (f3)
        3'd0: begin p = sx * sy; e.res = p[31:0];  e.lat = 33; end
        3'd1: begin p = sx * sy; e.res = p[63:32]; e.lat = 33; end
        3'd2: begin p = sx * uy; e.res = p[63:32]; e.lat = 33; end
        3'd3: begin p = ux * uy; e.res = p[63:32]; e.lat = 33; end
        3'd4: begin
          if (y == 0) e.res = 32'hFFFFFFFF;
          else if (x == 32'h80000000 && y == 32'hFFFFFFFF) e.res = x;
          else begin q = sx / sy; e.res = 32'(q); e.lat = 33; end
        end
        3'd5: begin
          if (y == 0) e.res = 32'hFFFFFFFF;
          else begin q = ux / uy; e.res = 32'(q); e.lat = 33; end
        end
        3'd6: begin
          if (y == 0) e.res = x;
          else if (x == 32'h80000000 && y == 32'hFFFFFFFF) e.res = 32'h0;
          else begin q = sx % sy; e.res = 32'(q); e.lat = 33; end
        end
        default: begin
          if (y == 0) e.res = x;
          else begin q = ux % uy; e.res = 32'(q); e.lat = 33; end
        end
      endcase
    end else begin
      case (f3)
        3'd0: e.res = (f7b5 && r_type) ? x - y : x + y;
        3'd1: e.res = x << y[4:0];
        3'd2: e.res = (sx < sy) ? 32'd1 : 32'd0;
        3'd3: e.res = (ux < uy) ? 32'd1 : 32'd0;
        3'd4: e.res = x ^ y;
        3'd5: e.res = f7b5 ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
        3'd6: e.res = x | y;
        default: e.res = x & y;
      endcase
    end
    return e;
  endfunction

  // Per-cycle compare against the model: handshake, timing and held outputs
  initial begin : compare
    logic exp_valid;
    logic was_empty;
    exp_t e;
    entry_t ent;
    logic after_reset;
    after_reset = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        after_reset = 1'b1;
      end else begin
        if (after_reset) begin
          check("reset out_valid", {31'b0, out_valid}, 32'd0);
          check("reset result", result, 32'd0);
          check("reset zero", {31'b0, zero}, 32'd1);
          check("reset illegal", {31'b0, illegal}, 32'd0);
          after_reset = 1'b0;
        end
        was_empty = (exp_q.size() == 0);
        check("in_ready", {31'b0, in_ready}, {31'b0, was_empty});
        if (was_empty) begin
          check("out_valid idle", {31'b0, out_valid}, 32'd0);
        end else begin
          exp_valid = (cyc >= exp_q[0].due);
          check("out_valid timing", {31'b0, out_valid}, {31'b0, exp_valid});
          if (out_valid && exp_valid) begin
            check("model result", result, exp_q[0].res);
            check("model zero", {31'b0, zero}, {31'b0, (exp_q[0].res == 32'h0)});
            check("model illegal", {31'b0, illegal}, {31'b0, exp_q[0].ill});
          end
        end
        if (was_empty && in_valid) begin
          e = model(alu_op, opb5, funct3, funct7b5, funct7b0, a, b);
          ent.res = e.res;
          ent.ill = e.ill;
          ent.due = cyc + e.lat;
          exp_q.push_back(ent);
        end else if (!was_empty && out_valid && out_ready && cyc >= exp_q[0].due) begin
          void'(exp_q.pop_front());
        end
      end
      cyc++;
    end
  end

  // Present one operation and hold it until the accepting edge
  task automatic applyStimulus(input logic [1:0] op, input logic r_type,
                               input logic [2:0] f3, input logic f7b5,
                               input logic f7b0, input logic [31:0] x,
                               input logic [31:0] y);
    int waited;
    @(posedge clk);
    #1;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) check("in_ready wait", {31'b0, in_ready}, 32'd1);
    alu_op   = op;
    opb5     = r_type;
    funct3   = f3;
    funct7b5 = f7b5;
    funct7b0 = f7b0;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 32'hDEADBEEF;
    b        = 32'h12345678;
  endtask

  // Wait for the result and compare it and its latency with literals
  task automatic checkOutput(input string name, input logic [31:0] exp_res,
                             input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    check({name, " result"}, result, exp_res);
    check({name, " zero"}, {31'b0, zero}, {31'b0, (exp_res == 32'h0)});
    check({name, " latency"}, lat, exp_lat);
  endtask

  task automatic runOp(input string name, input logic [1:0] op, input logic r_type,
                       input logic [2:0] f3, input logic f7b5, input logic f7b0,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_res, input int exp_lat);
    applyStimulus(op, r_type, f3, f7b5, f7b0, x, y);
    checkOutput(name, exp_res, exp_lat);
  endtask

  initial begin : stimulus
    exp_t m;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_op    = 2'b00;
    opb5      = 1'b0;
    funct3    = 3'b000;
    funct7b5  = 1'b0;
    funct7b0  = 1'b0;
    a         = 32'h0;
    b         = 32'h0;

    // Pin the reference model to hand-computed values
    m = model(2'b10, 1'b1, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7);
    check("model pin SUB", m.res, 32'hFFFFFFFE);
    m = model(2'b10, 1'b1, 3'd1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("model pin MULH", m.res, 32'h00000000);
    m = model(2'b10, 1'b1, 3'd3, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("model pin MULHU", m.res, 32'hFFFFFFFE);
    m = model(2'b10, 1'b1, 3'd4, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    check("model pin DIV", m.res, 32'hFFFFFFFD);
    m = model(2'b10, 1'b1, 3'd6, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    check("model pin REM", m.res, 32'hFFFFFFFF);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    runOp("SUB r",      2'b10, 1, 3'd0, 1, 0, 32'd5,        32'd7,        32'hFFFFFFFE, 1);
    runOp("MULH",       2'b10, 1, 3'd1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    runOp("MULHU",      2'b10, 1, 3'd3, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    runOp("DIV",        2'b10, 1, 3'd4, 0, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    runOp("REM",        2'b10, 1, 3'd6, 0, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    runOp("DIV ovf",    2'b10, 1, 3'd4, 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    runOp("REM ovf",    2'b10, 1, 3'd6, 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    runOp("DIVU by 0",  2'b10, 1, 3'd5, 0, 1, 32'd7,        32'd0,        32'hFFFFFFFF, 1);
    runOp("REMU by 0",  2'b10, 1, 3'd7, 0, 1, 32'd7,        32'd0,        32'h00000007, 1);
    runOp("MUL",        2'b10, 1, 3'd0, 0, 1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 33);
    runOp("MULHSU",     2'b10, 1, 3'd2, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    runOp("DIVU",       2'b10, 1, 3'd5, 0, 1, 32'd100,      32'd7,        32'h0000000E, 33);
    runOp("REMU",       2'b10, 1, 3'd7, 0, 1, 32'd100,      32'd7,        32'h00000002, 33);
    runOp("REM negdiv", 2'b10, 1, 3'd6, 0, 1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 33);
    runOp("SRA",        2'b10, 0, 3'd5, 1, 0, 32'h80000000, 32'd4,        32'hF8000000, 1);
    runOp("SRL",        2'b10, 1, 3'd5, 0, 0, 32'h80000000, 32'h0000003F, 32'h00000001, 1);
    runOp("SLT",        2'b10, 1, 3'd2, 0, 0, 32'hFFFFFFFF, 32'd1,        32'h00000001, 1);
    runOp("SLTU",       2'b10, 1, 3'd3, 0, 0, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1);
    runOp("XOR",        2'b10, 1, 3'd4, 0, 0, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 1);
    runOp("OR",         2'b10, 1, 3'd6, 0, 0, 32'h0000F0F0, 32'h00000FF0, 32'h0000FFF0, 1);
    runOp("AND",        2'b10, 1, 3'd7, 0, 0, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1);
    runOp("ADD wrap",   2'b00, 0, 3'd0, 0, 0, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1);
    runOp("SUB class",  2'b01, 0, 3'd0, 0, 0, 32'd10,       32'd3,        32'h00000007, 1);
    runOp("I-type ADD", 2'b10, 0, 3'd0, 1, 1, 32'd2,        32'd3,        32'h00000005, 1);
    runOp("ILLEGAL",    2'b11, 1, 3'd0, 0, 0, 32'd5,        32'd5,        32'h00000000, 1);

    // Backpressure: result must stay put while the consumer stalls
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    runOp("SLL bp",     2'b10, 1, 3'd1, 0, 0, 32'd1,        32'h00000025, 32'h00000020, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp held result", result, 32'h00000020);
      check("bp in_ready low", {31'b0, in_ready}, 32'd0);
      check("bp out_valid high", {31'b0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp in_ready after take", {31'b0, in_ready}, 32'd1);

    // Reset during a long divide, in cycle k+10
    applyStimulus(2'b10, 1, 3'd5, 0, 1, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort in_ready", {31'b0, in_ready}, 32'd1);
    check("abort out_valid", {31'b0, out_valid}, 32'd0);
    check("abort result", result, 32'd0);
    check("abort zero", {31'b0, zero}, 32'd1);
    runOp("ADD after abort", 2'b00, 0, 3'd0, 0, 0, 32'd2, 32'd3, 32'h00000005, 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
